cfg_write_arbiter: RTL and testbench
====================================

// Module: cfg_write_arbiter
// PURPOSE
// - Owns the write path of the config register bank (reg_0..reg_4) that drives the PWM/output logic.
// - Arbitrates register writes between two requesters:
//   - port 0: SPI peripheral decoded writes.
//   - port 1: on-chip host/sequencer.
// - Fair round-robin grant, valid/ready handshake, one write committed at a time.
// - Out-of-range and blocked writes are accepted, dropped and flagged.
// PARAMETERS
// - NUM_REGS  5  number of 8-bit config registers, addresses 0..NUM_REGS-1
// - ADDR_W    7  write address width, same as the SPI address field
// - DATA_W    8  register width
// PORTS
// - clk        in   1                 single system clock; all logic on posedge
// - rst        in   1                 synchronous, active-high reset
// - p0_valid   in   1                 port 0 write request
// - p0_addr    in   ADDR_W            port 0 target address
// - p0_data    in   DATA_W            port 0 write data
// - p0_ready   out  1                 port 0 accept pulse
// - p1_valid   in   1                 port 1 write request
// - p1_addr    in   ADDR_W            port 1 target address
// - p1_data    in   DATA_W            port 1 write data
// - p1_ready   out  1                 port 1 accept pulse
// - cfg_regs   out  NUM_REGS*DATA_W   register bank; reg k at [k*DATA_W +: DATA_W]
// - wr_err     out  1                 one-cycle pulse: accepted write was dropped
// - busy       out  1                 high while the FSM is not in IDLE
// BEHAVIOUR
// - Reset (rst high at posedge):
//   - cfg_regs=0, p0_ready=p1_ready=0, wr_err=0, busy=0.
//   - FSM=IDLE; round-robin pointer favours port 0.
//   - Any in-flight write is discarded.
// - FSM states: IDLE -> ACCEPT -> COMMIT -> IDLE.
// - IDLE:
//   - If either valid is high, latch the winner's addr/data, register the winner ID, go to ACCEPT.
//   - Otherwise stay in IDLE.
// - Winner selection:
//   - Only one valid high: that port wins.
//   - Both valid high: the favoured port wins.
// - ACCEPT:
//   - Winner's ready is high for exactly this one cycle; the other ready stays 0.
//   - Pointer updates to favour the non-winner.
//   - Go to COMMIT.
// - COMMIT:
//   - If addr < NUM_REGS (and not blocked), write the latched data to that register.
//   - Otherwise no register changes and wr_err pulses for this cycle.
//   - Go to IDLE.
// - Latency:
//   - valid sampled at edge N -> ready high during cycle N+1.
//   - New cfg_regs value visible after edge N+2.
//   - Sustained throughput: one write per 3 cycles.
// - Requester contract:
//   - Hold valid/addr/data stable until ready is seen.
//   - Drop valid after ready.
//   - Data is latched in IDLE; later changes are ignored.
// - Back-to-back traffic:
//   - Port still valid in IDLE right after COMMIT re-enters arbitration normally.
//   - Pointer guarantees alternation when both ports are continuously valid.
// - Address width: the full ADDR_W field is compared; upper bits are never truncated (e.g. 0x45 is invalid, not 0x05).
// - cfg_regs holds its value at all times other than COMMIT; no glitching on rejected writes.
// CONFIGURATION
// - Macro CFG_ARB_LOCK_EN defined:
//   - Address NUM_REGS is an internal lock register (bit 0 = lock; reset 0; not on cfg_regs).
//   - The lock register is writable only from port 1; a port 0 write to it is dropped with wr_err.
//   - While lock=1, every port 0 write is accepted (ready pulses), dropped, and pulses wr_err.
//   - Port 1 writes are never blocked.
//   - Lock evaluation uses the lock value at COMMIT time.
// - Macro undefined:
//   - No lock register; address NUM_REGS is out of range (wr_err).
//   - Both ports are equal.
// TESTING
// - Reset then idle 5 cycles -> cfg_regs=0, busy=0, no ready or wr_err pulses.
// - p0 write addr 0x02 data 0xA5 at edge N -> p0_ready during N+1; reg_2=0xA5 after N+2; other regs 0.
// - p0 and p1 valid same cycle after reset (p0: 0x00/0x11, p1: 0x00/0x22):
//   - p0 granted first, then p1.
//   - reg_0 ends at 0x22; ready pulses alternate.
// - p1 write addr 0x07 data 0xFF -> p1_ready pulses, wr_err pulses in COMMIT, cfg_regs unchanged.
// - rst asserted during ACCEPT of a p0 write to addr 0x01 -> reg_1 stays 0, FSM IDLE, pointer favours p0.
// - CFG_ARB_LOCK_EN defined:
//   - p1 writes addr 0x05 data 0x01, then p0 writes 0x03/0x5A -> p0_ready pulses, wr_err pulses, reg_3 stays 0.
//   - p1 writes 0x03/0x5A -> reg_3=0x5A.

Source files
------------

// File: rtl/cfg_write_arbiter_if.sv
// Write-request bundle between the two config requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface cfg_write_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              p0_valid;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_data;
    logic              p0_ready;
    logic              p1_valid;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_data;
    logic              p1_ready;

    modport master (
        output p0_valid, p0_addr, p0_data, p1_valid, p1_addr, p1_data,
        input  p0_ready, p1_ready
    );

    modport slave (
        input  p0_valid, p0_addr, p0_data, p1_valid, p1_addr, p1_data,
        output p0_ready, p1_ready
    );
endinterface

// File: rtl/cfg_write_arbiter.sv
// Round-robin write arbiter owning the config register bank (SPI port 0, host port 1).
// Optional CFG_ARB_LOCK_EN adds a port-1-only lock register at address NUM_REGS.
module cfg_write_arbiter #(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    cfg_write_arbiter_if.slave         wr,
    output logic [NUM_REGS*DATA_W-1:0] cfg_regs,
    output logic                       wr_err,
    output logic                       busy
);
    typedef enum logic [1:0] {IDLE, ACCEPT, COMMIT} state_t;

    state_t            state, state_nxt;
    logic              fav_p1;
    logic              win_p1;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              any_valid, grant_p1, hit, drop;

    assign any_valid = wr.p0_valid | wr.p1_valid;
    assign grant_p1  = wr.p1_valid & (~wr.p0_valid | fav_p1);
    // Full-width compare: an address like 0x45 must not alias onto a real register.
    assign hit       = addr_q < ADDR_W'(NUM_REGS);

`ifdef CFG_ARB_LOCK_EN
    logic lock_q;
    logic lock_wr;

    assign lock_wr = win_p1 & (addr_q == ADDR_W'(NUM_REGS));
    assign drop    = ~lock_wr & (~hit | (~win_p1 & lock_q));

    always_ff @(posedge clk) begin
        if (rst)
            lock_q <= 1'b0;
        else if (state == COMMIT && lock_wr)
            lock_q <= data_q[0];
    end
`else
    assign drop = ~hit;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = ACCEPT;
            ACCEPT:  state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr.p0_ready = 1'b0;
        wr.p1_ready = 1'b0;
        wr_err      = 1'b0;
        busy        = (state != IDLE);
        case (state)
            ACCEPT: begin
                wr.p0_ready = ~win_p1;
                wr.p1_ready = win_p1;
            end
            COMMIT:  wr_err = drop;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fav_p1 <= 1'b0;
            win_p1 <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (state == IDLE && any_valid) begin
                win_p1 <= grant_p1;
                addr_q <= grant_p1 ? wr.p1_addr : wr.p0_addr;
                data_q <= grant_p1 ? wr.p1_data : wr.p0_data;
            end
            if (state == ACCEPT)
                fav_p1 <= ~win_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else if (state == COMMIT && !drop) begin
            for (int k = 0; k < NUM_REGS; k++)
                if (addr_q == ADDR_W'(k)) regs[k] <= data_q;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign cfg_regs[k*DATA_W +: DATA_W] = regs[k];
    end
endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Bench for cfg_write_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-timestamp model.
module tb_cfg_write_arbiter;
    localparam int NR = 5;
    localparam int AW = 7;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR*DW-1:0] cfg_regs;
    logic             wr_err, busy;
    int               errors = 0;
    int               checks = 0;

    cfg_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cfg_write_arbiter #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .wr(bus), .cfg_regs(cfg_regs), .wr_err(wr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a write granted at edge g shows ready in the cycle after g, its
    // error (if any) in the cycle after g+1, lands at edge g+2; next grant at g+3.
    int          m_cyc = 0;
    int          m_g = 0;
    bit          m_act = 0, m_win = 0, m_fav = 0, m_drop = 0, m_lock = 0;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_regs [NR];

    function automatic bit dropped(input bit win, input logic [AW-1:0] a);
`ifdef CFG_ARB_LOCK_EN
        if (a == AW'(NR)) return !win;
        if (a > AW'(NR))  return 1'b1;
        return !win && m_lock;
`else
        return a >= AW'(NR);
`endif
    endfunction

    task automatic model_step();
        m_cyc++;
        if (rst) begin
            m_act = 0; m_fav = 0; m_lock = 0;
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
        end else if (m_act) begin
            if (m_cyc - m_g == 2) begin
                if (!m_drop) begin
                    if (m_addr < AW'(NR)) m_regs[int'(m_addr)] = m_data;
                    else                  m_lock = m_data[0];
                end
                m_act = 0;
            end
        end else if (bus.p0_valid || bus.p1_valid) begin
            m_win  = bus.p1_valid && (!bus.p0_valid || m_fav);
            m_fav  = !m_win;
            m_addr = m_win ? bus.p1_addr : bus.p0_addr;
            m_data = m_win ? bus.p1_data : bus.p0_data;
            m_drop = dropped(m_win, m_addr);
            m_g    = m_cyc;
            m_act  = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        logic [NR*DW-1:0] exp_cfg;
        int d;
        @(negedge clk);
        d = m_cyc - m_g;
        for (int i = 0; i < NR; i++) exp_cfg[i*DW +: DW] = m_regs[i];
        check("m_p0_ready", 64'(bus.p0_ready), 64'(m_act && d == 0 && !m_win));
        check("m_p1_ready", 64'(bus.p1_ready), 64'(m_act && d == 0 && m_win));
        check("m_wr_err",   64'(wr_err),       64'(m_act && d == 1 && m_drop));
        check("m_busy",     64'(busy),         64'(m_act));
        check("m_cfg_regs", 64'(cfg_regs),     64'(exp_cfg));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input bit port, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] dt);
        if (port) begin bus.p1_valid = v; bus.p1_addr = a; bus.p1_data = dt; end
        else      begin bus.p0_valid = v; bus.p0_addr = a; bus.p0_data = dt; end
    endtask

    // Full write on an otherwise quiet bus; returns at the idle cycle after commit.
    task automatic do_write(input bit port, input logic [AW-1:0] a, input logic [DW-1:0] dt, input bit exp_err);
        bit seen = 0;
        set_req(port, 1'b1, a, dt);
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            seen = port ? bus.p1_ready : bus.p0_ready;
        end
        if (!seen) check("ready_timeout", 64'd0, 64'd1);
        set_req(port, 1'b0, a, dt);
        tick();
        check("wr_err_commit", 64'(wr_err), 64'(exp_err));
        tick();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 9))
            6:       return AW'(NR);
            7:       return 7'h07;
            8:       return 7'h45;
            9:       return AW'($urandom_range(0, 127));
            default: return AW'($urandom_range(0, NR - 1));
        endcase
    endfunction

    initial begin
        set_req(0, 0, '0, '0);
        set_req(1, 0, '0, '0);
        repeat (2) tick();
        rst = 1'b0;

        // Quiet after reset
        repeat (5) begin
            tick();
            check("idle_outputs", 64'({bus.p0_ready, bus.p1_ready, wr_err, busy}), 64'd0);
        end
        check("idle_regs", 64'(cfg_regs), 64'd0);

        // Single p0 write, latency
        set_req(0, 1, 7'h02, 8'hA5);
        tick();
        check("p0_ready_n1", 64'({bus.p0_ready, bus.p1_ready}), 64'b10);
        set_req(0, 0, 7'h02, 8'hA5);
        tick();
        check("p0_regs_before", 64'(cfg_regs), 64'd0);
        tick();
        check("p0_regs_after", 64'(cfg_regs), 64'h00_00_A5_00_00);

        // Simultaneous requests after reset: p0 first, then p1
        rst = 1'b1; tick(); rst = 1'b0;
        set_req(0, 1, 7'h00, 8'h11);
        set_req(1, 1, 7'h00, 8'h22);
        tick();
        check("both_first", 64'({bus.p0_ready, bus.p1_ready}), 64'b10);
        set_req(0, 0, 7'h00, 8'h11);
        tick();
        tick();
        check("both_mid_reg0", 64'(cfg_regs), 64'h11);
        tick();
        check("both_second", 64'({bus.p0_ready, bus.p1_ready}), 64'b01);
        set_req(1, 0, 7'h00, 8'h22);
        tick();
        tick();
        check("both_final_reg0", 64'(cfg_regs), 64'h22);

        // Out-of-range write from p1
        do_write(1, 7'h07, 8'hFF, 1'b1);
        check("oor_unchanged", 64'(cfg_regs), 64'h22);

        // Reset during ACCEPT of a p0 write
        set_req(0, 1, 7'h01, 8'h77);
        tick();
        check("rst_acc_ready", 64'(bus.p0_ready), 64'd1);
        set_req(0, 0, 7'h01, 8'h77);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_acc_regs", 64'(cfg_regs), 64'd0);
        check("rst_acc_busy", 64'(busy), 64'd0);
        set_req(0, 1, 7'h04, 8'h33);
        set_req(1, 1, 7'h04, 8'h44);
        tick();
        check("rst_ptr_p0", 64'({bus.p0_ready, bus.p1_ready}), 64'b10);
        set_req(0, 0, 7'h04, 8'h33);
        repeat (3) tick();
        check("rst_ptr_then_p1", 64'({bus.p0_ready, bus.p1_ready}), 64'b01);
        set_req(1, 0, 7'h04, 8'h44);
        repeat (2) tick();
        check("reg4_last", 64'(cfg_regs), 64'h44_00_00_00_00);

`ifdef CFG_ARB_LOCK_EN
        do_write(1, 7'h05, 8'h01, 1'b0);
        do_write(0, 7'h03, 8'h5A, 1'b1);
        check("locked_p0_dropped", 64'(cfg_regs), 64'h44_00_00_00_00);
        do_write(1, 7'h03, 8'h5A, 1'b0);
        check("locked_p1_writes", 64'(cfg_regs), 64'h44_5A_00_00_00);
        do_write(0, 7'h05, 8'h00, 1'b1);
        do_write(1, 7'h05, 8'h00, 1'b0);
        do_write(0, 7'h00, 8'h66, 1'b0);
        check("unlocked_p0", 64'(cfg_regs), 64'h44_5A_00_00_66);
`else
        do_write(0, 7'h05, 8'h01, 1'b1);
        do_write(0, 7'h03, 8'h5A, 1'b0);
        check("p0_reg3", 64'(cfg_regs), 64'h44_5A_00_00_00);
`endif
        do_write(0, 7'h45, 8'h99, 1'b1);
        check("alias_0x45", 64'(cfg_regs[7:0]), 64'(cfg_regs[7:0] == 8'h66 ? 8'h66 : 8'h00));

        // Random traffic, requesters obey the hold-until-ready contract
        repeat (3000) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            if (bus.p0_valid && bus.p0_ready) bus.p0_valid = 1'b0;
            else if (!bus.p0_valid && $urandom_range(0, 2) == 0)
                set_req(0, 1, rand_addr(), DW'($urandom_range(0, 255)));
            if (bus.p1_valid && bus.p1_ready) bus.p1_valid = 1'b0;
            else if (!bus.p1_valid && $urandom_range(0, 2) == 0)
                set_req(1, 1, rand_addr(), DW'($urandom_range(0, 255)));
        end
        rst = 1'b0;
        set_req(0, 0, '0, '0);
        set_req(1, 0, '0, '0);
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
